// File: rtl/acc_postproc_mc_pkg.sv
// acc_pp_pkg: activation codes and saturate/round helpers shared by the post-accumulation stage
package acc_pp_pkg;
  localparam int ACT_NONE  = 0;
  localparam int ACT_RELU  = 1;
  localparam int ACT_RELU6 = 2;
  localparam int ACT_LEAKY = 3;
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v, input int w);
    logic signed [63:0] mx, mn;
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = -(64'sd1 <<< (w - 1));
    return v > mx ? mx : v < mn ? mn : v;
  endfunction
  function automatic logic signed [63:0] round_shift(input logic signed [63:0] v, input int l);
    return l == 0 ? v : (v + (64'sd1 <<< (l - 1))) >>> l;
  endfunction
endpackage

// File: rtl/acc_postproc_mc_if.sv
// acc_postproc_mc_if: accumulator stream, parameter write port and result stream
interface acc_postproc_mc_if #(
  parameter int ACC_WIDTH = 40,
  parameter int CH_AW     = 4,
  parameter int DOUT_DW   = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [ACC_WIDTH-1:0] acc_in;
  logic                 ch_clear;
  logic                 param_we;
  logic [CH_AW-1:0]     param_addr;
  logic [31:0]          param_wdata;
  logic                 out_valid;
  logic                 out_ready;
  logic [DOUT_DW-1:0]   out_data;
  logic [CH_AW-1:0]     out_ch;
  logic                 out_last;
  modport master (
    output in_valid, acc_in, ch_clear, param_we, param_addr, param_wdata, out_ready,
    input  in_ready, out_valid, out_data, out_ch, out_last
  );
  modport slave (
    input  in_valid, acc_in, ch_clear, param_we, param_addr, param_wdata, out_ready,
    output in_ready, out_valid, out_data, out_ch, out_last
  );
endinterface

// File: rtl/acc_postproc_mc_param_ram.sv
// acc_pp_param_ram: NUM_CH x 32 parameter table, one write port and one enabled synchronous read port
module acc_pp_param_ram #(
  parameter int NUM_CH = 16,
  parameter int CH_AW  = 4
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [CH_AW-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic             re_i,
  input  logic [CH_AW-1:0] raddr_i,
  output logic [31:0]      rdata_o
);
  localparam int AW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic [31:0] mem_q [NUM_CH];
  always_ff @(posedge clk) begin
    if (we_i && int'(waddr_i) < NUM_CH) mem_q[waddr_i[AW-1:0]] <= wdata_i;
    if (re_i) rdata_o <= int'(raddr_i) < NUM_CH ? mem_q[raddr_i[AW-1:0]] : '0;
  end
endmodule

// File: rtl/acc_postproc_mc.sv
// acc_postproc_mc: round-robin multi-channel bias/batch-norm, round, saturate and activation stage
module acc_postproc_mc import acc_pp_pkg::*; #(
  parameter int NUM_CH     = 16,
  parameter int CH_AW      = 4,
  parameter int ACC_WIDTH  = 40,
  parameter int Q          = 8,
  parameter int DIN_Q      = 6,
  parameter int DOUT_DW    = 16,
  parameter int DOUT_Q     = 6,
  parameter int BIAS_DW    = 16,
  parameter int BN         = 0,
  parameter int MID_Q      = 13,
  parameter int BN_SCALE_Q = 13,
  parameter int BN_BIAS_Q  = 13,
  parameter int ACT        = ACT_NONE
) (
  input logic clk,
  input logic rst,
  acc_postproc_mc_if.slave bus
);
  localparam int SW  = BN != 0 ? 33 : ACC_WIDTH + 1;
  localparam int L   = BN != 0 ? MID_Q + BN_SCALE_Q - DOUT_Q : Q + DIN_Q - DOUT_Q;
  localparam int MSH = Q + DIN_Q - MID_Q;
  localparam int BSH = MID_Q + BN_SCALE_Q - BN_BIAS_Q;
  localparam logic [CH_AW-1:0] LAST = CH_AW'(NUM_CH - 1);
  localparam logic signed [DOUT_DW-1:0] ZERO = '0;
  localparam logic signed [DOUT_DW-1:0] SIX = DOUT_DW'(6 << DOUT_Q);
  logic en, acc_en;
  logic [CH_AW-1:0] cnt_q, cnt_d, ch1_q, ch2_q, ch3_q, out_ch_q;
  logic [2:0] v_q;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic [31:0] par;
  logic signed [15:0] mid, bnb_q;
  logic signed [31:0] prod;
  logic signed [63:0] s2_64, s3_64, r64;
  logic signed [SW-1:0] s2_q, s2_d, s3_q, s3_d;
  logic signed [DOUT_DW-1:0] sv, lk, act_d, out_data_q;
  logic out_valid_q, out_last_q;
  assign en            = ~(out_valid_q & ~bus.out_ready);
  assign bus.in_ready  = en;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_last  = out_last_q;
  acc_pp_param_ram #(.NUM_CH(NUM_CH), .CH_AW(CH_AW)) u_ram (
    .clk(clk), .we_i(bus.param_we), .waddr_i(bus.param_addr), .wdata_i(bus.param_wdata),
    .re_i(en), .raddr_i(cnt_q), .rdata_o(par)
  );
  always_comb begin
    acc_en = bus.in_valid & en;
    cnt_d  = bus.ch_clear ? '0 : !acc_en ? cnt_q : cnt_q == LAST ? '0 : cnt_q + 1'b1;
    mid    = 16'(sat_signed(64'(acc_q) >>> MSH, 16));
    prod   = 32'(mid) * 32'(signed'(par[15:0]));
    s2_64  = BN != 0 ? 64'(prod) : 64'(acc_q) + (64'(signed'(par[BIAS_DW-1:0])) <<< DIN_Q);
    s2_d   = SW'(s2_64);
    s3_64  = BN != 0 ? 64'(s2_q) + (64'(bnb_q) <<< BSH) : 64'(s2_q);
    s3_d   = SW'(s3_64);
    r64    = sat_signed(round_shift(64'(s3_q), L), DOUT_DW);
    sv     = DOUT_DW'(r64);
    lk     = sv >>> 3;
    act_d  = ACT == ACT_RELU  ? (sv[DOUT_DW-1] ? ZERO : sv)
           : ACT == ACT_RELU6 ? (sv[DOUT_DW-1] ? ZERO : sv > SIX ? SIX : sv)
           : ACT == ACT_LEAKY ? (sv[DOUT_DW-1] ? lk : sv) : sv;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      v_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_last_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (en) begin
        v_q         <= {v_q[1:0], acc_en};
        acc_q       <= bus.acc_in;
        ch1_q       <= cnt_q;
        ch2_q       <= ch1_q;
        ch3_q       <= ch2_q;
        s2_q        <= s2_d;
        bnb_q       <= par[31:16];
        s3_q        <= s3_d;
        out_valid_q <= v_q[2];
        out_data_q  <= act_d;
        out_ch_q    <= ch3_q;
        out_last_q  <= ch3_q == LAST;
      end
    end
  end
endmodule

// File: tb/tb_acc_postproc_mc.sv
// tb_acc_postproc_mc: scoreboard bench over five configurations of the post-accumulation stage
module tb_acc_postproc_mc;
  logic clk, rst;
  logic [4:0] in_valid, ch_clear, param_we, out_ready;
  logic [4:0][39:0] acc_in;
  logic [4:0][3:0] param_addr;
  logic [4:0][31:0] param_wdata;
  logic [4:0] in_ready, out_valid, out_last;
  logic [4:0][15:0] out_data;
  logic [4:0][3:0] out_ch;
  logic [20:0] q [5][$];
  logic [20:0] mon_e;
  int checks, errors;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 5; g++) begin : gi
    acc_postproc_mc_if #(.ACC_WIDTH(40), .CH_AW(4), .DOUT_DW(16)) b ();
    assign b.in_valid    = in_valid[g];
    assign b.acc_in      = acc_in[g];
    assign b.ch_clear    = ch_clear[g];
    assign b.param_we    = param_we[g];
    assign b.param_addr  = param_addr[g];
    assign b.param_wdata = param_wdata[g];
    assign b.out_ready   = out_ready[g];
    assign in_ready[g]   = b.in_ready;
    assign out_valid[g]  = b.out_valid;
    assign out_data[g]   = b.out_data;
    assign out_ch[g]     = b.out_ch;
    assign out_last[g]   = b.out_last;
    acc_postproc_mc #(
      .NUM_CH(g == 1 ? 4 : 16), .BN(g == 4 ? 1 : 0), .ACT(g < 4 ? g : 0)
    ) u (.clk(clk), .rst(rst), .bus(b));
  end
  function automatic logic [20:0] mk(input bit l, input int c, input int d);
    return {l, c[3:0], d[15:0]};
  endfunction
  function automatic int pending();
    int n = 0;
    for (int i = 0; i < 5; i++) n += q[i].size();
    return n;
  endfunction
  function automatic logic [31:0] pv(input int i, input int a);
    if (i == 0 && a == 0) return 32'd256;
    if (i == 4 && a == 0) return 32'h2000_2000;
    if (i == 4 && a < 3) return 32'h0000_2000;
    return 32'd0;
  endfunction
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 5; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          checks++;
          if (q[i].size() == 0) begin
            errors++;
            $display("FAIL out%0d unexpected: got ch=%0d data=%0d required nothing", i, out_ch[i], $signed(out_data[i]));
          end else begin
            mon_e = q[i].pop_front();
            if ({out_last[i], out_ch[i], out_data[i]} !== mon_e) begin
              errors++;
              $display("FAIL out%0d: got last=%0d ch=%0d data=%0d required last=%0d ch=%0d data=%0d",
                       i, out_last[i], out_ch[i], $signed(out_data[i]), mon_e[20], mon_e[19:16], $signed(mon_e[15:0]));
            end
          end
        end
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input int i, input longint a, input logic [20:0] e, input bit clr = 1'b0);
    int n = 0;
    bit ok;
    in_valid[i] = 1'b1;
    acc_in[i]   = 40'(a);
    ch_clear[i] = clr;
    do begin
      @(negedge clk);
      ok = in_ready[i];
      tick(1);
      n++;
    end while (!ok && n < 100);
    in_valid[i] = 1'b0;
    ch_clear[i] = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept%0d: got no in_ready in 100 cycles required accept", i);
    end else q[i].push_back(e);
  endtask
  task automatic wr(input int i, input int a, input logic [31:0] d);
    param_we[i]    = 1'b1;
    param_addr[i]  = a[3:0];
    param_wdata[i] = d;
    tick(1);
    param_we[i] = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (pending() != 0 && n < 100) begin
      tick(1);
      n++;
    end
    checks++;
    if (pending() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending results required 0", pending());
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    in_valid = '0;
    ch_clear = '0;
    param_we = '0;
    out_ready = '1;
    acc_in = '0;
    param_addr = '0;
    param_wdata = '0;
    tick(3);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({in_ready[i], out_valid[i], out_last[i], out_ch[i], out_data[i]} !== {1'b1, 22'd0}) begin
        errors++;
        $display("FAIL reset%0d: got rdy=%0d vld=%0d last=%0d ch=%0d data=%0d required rdy=1 others 0",
                 i, in_ready[i], out_valid[i], out_last[i], out_ch[i], out_data[i]);
      end
    end
    tick(1);
    rst = 1'b0;
    for (int i = 0; i < 5; i++)
      for (int a = 0; a < (i == 1 ? 4 : 16); a++) wr(i, a, pv(i, a));
    send(0, 49152, mk(0, 0, 256));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid[0] !== (c == 3)) begin
        errors++;
        $display("FAIL latency cycle %0d: got out_valid=%0d required %0d", c + 1, out_valid[0], c == 3);
      end
    end
    tick(1);
    send(0, 128, mk(0, 1, 1));
    send(0, 127, mk(0, 2, 0));
    send(0, -128, mk(0, 3, 0));
    send(0, -129, mk(0, 4, -1));
    send(0, 1073741824, mk(0, 5, 32767));
    send(0, -1073741824, mk(0, 6, -32768));
    send(2, 114688, mk(0, 0, 384));
    send(2, 98304, mk(0, 1, 384));
    send(2, -16384, mk(0, 2, 0));
    send(2, 49152, mk(0, 3, 192));
    send(3, -16384, mk(0, 0, -8));
    send(3, -25600, mk(0, 1, -13));
    send(3, 49152, mk(0, 2, 192));
    send(4, 32768, mk(0, 0, 192));
    send(4, 1073741824, mk(0, 1, 256));
    send(4, -32768, mk(0, 2, -128));
    for (int k = 0; k < 10; k++)
      send(1, k == 0 ? -1073741824 : k << 8, mk(k % 4 == 3, k % 4, k));
    ch_clear[1] = 1'b1;
    tick(1);
    ch_clear[1] = 1'b0;
    send(1, 5 << 8, mk(0, 0, 5));
    send(1, 6 << 8, mk(0, 1, 6), 1'b1);
    send(1, 7 << 8, mk(0, 0, 7));
    drain();
    fork
      for (int k = 1; k <= 8; k++) send(1, (10 + k) << 8, mk(k % 4 == 3, k % 4, 10 + k));
      begin
        tick(6);
        out_ready[1] = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          checks++;
          if ({in_ready[1], out_valid[1], out_data[1]} !== {1'b0, 1'b1, 16'd13}) begin
            errors++;
            $display("FAIL stall cycle %0d: got rdy=%0d vld=%0d data=%0d required rdy=0 vld=1 data=13",
                     c, in_ready[1], out_valid[1], $signed(out_data[1]));
          end
        end
        tick(1);
        out_ready[1] = 1'b1;
      end
    join
    drain();
    for (int k = 0; k < 5; k++) send(1, (20 + k) << 8, mk(k == 2, (k + 1) % 4, 20 + k));
    rst = 1'b1;
    for (int i = 0; i < 5; i++) q[i].delete();
    tick(1);
    @(negedge clk);
    checks++;
    if ({out_valid[1], out_last[1], out_ch[1], out_data[1]} !== 22'd0) begin
      errors++;
      $display("FAIL midreset: got vld=%0d last=%0d ch=%0d data=%0d required all 0",
               out_valid[1], out_last[1], out_ch[1], out_data[1]);
    end
    tick(1);
    rst = 1'b0;
    send(1, 3 << 8, mk(0, 0, 3));
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
